bram_arbiter: RTL and testbench

// - Shares one bram_rv instance between the instruction-fetch port (read-only) and the load/store data port.
// - Per-port request/response ready/valid channels; one transaction in flight to memory at a time.
// - Sits between the core front-end/LSU and bram_rv; addresses are word addresses, byte lanes via byte-enable.

---
 rtl/bram_arb_pkg.sv | 37 +++
 rtl/bram_arb_picker.sv | 51 +++++
 rtl/bram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_bram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// ============================================================================
// Module : bram_arb_pkg
// Purpose: Shared types and constants for the bram_arbiter slice.
//          state_t - arbiter transaction FSM states
//          owner_t - which client owns the in-flight transaction
//          BE_W    - byte-enable width for the default 32-bit word
//          other_port() - returns the opposite client, used by the
//                         round-robin pointer update
// Config : BRAM_ARB_RR_EN (see bram_arbiter) selects round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_W           = DEF_DATA_WIDTH / 8;

  function automatic owner_t other_port(input owner_t o);
    return (o == OWN_F) ? OWN_D : OWN_F;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_arb_picker.sv
// ============================================================================
// Module : bram_arb_picker
// Purpose: Purely combinational grant selection between the fetch and data
//          clients. The round-robin pointer lives in the parent; this block
//          only decides who wins in the current cycle.
// Ports  : f_valid  in  fetch request valid
//          d_valid  in  data request valid
//          rr_ptr   in  preferred client when both request (round-robin only)
//          grant_f  out fetch wins this cycle
//          grant_d  out data wins this cycle
// Config : BRAM_ARB_RR_EN defined   -> round-robin on rr_ptr
//          BRAM_ARB_RR_EN undefined -> fixed priority, data over fetch
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_arb_picker
  import bram_arb_pkg::*;
(
  input  logic   f_valid,
  input  logic   d_valid,
  input  owner_t rr_ptr,
  output logic   grant_f,
  output logic   grant_d
);

`ifdef BRAM_ARB_RR_EN
  // A lone requester always wins; contention is settled by the pointer.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (f_valid && d_valid) begin
      if (rr_ptr == OWN_D) grant_d = 1'b1;
      else                 grant_f = 1'b1;
    end else begin
      grant_f = f_valid;
      grant_d = d_valid;
    end
  end
`else
  // Fixed priority does not consult the pointer.
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  assign grant_d = d_valid;
  assign grant_f = f_valid && !d_valid;
`endif

endmodule

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module : bram_arbiter
// Purpose: Shares one bram_rv port between the instruction-fetch client
//          (read-only) and the load/store data client. One transaction is in
//          flight to memory at a time; each client has its own request and
//          response ready/valid channels. Addresses are word addresses.
// Ports  : i_clk, i_rst_n           clock / asynchronous active-low reset
//          i_f_req_valid/o_f_req_ready/i_f_addr         fetch request
//          o_f_resp_valid/i_f_resp_ready/o_f_rdata      fetch response
//          i_d_req_valid/o_d_req_ready/i_d_addr/i_d_we/
//          i_d_wdata/i_d_be                             data request
//          o_d_resp_valid/i_d_resp_ready/o_d_rdata      data response
//          o_mem_addr/o_mem_data/o_mem_wr_valid/o_mem_rd_ready/
//          o_mem_byte_write_enable                      to bram_rv
//          i_mem_wr_ready/i_mem_rd_valid/i_mem_data     from bram_rv
// Config : BRAM_ARB_RR_EN - when defined, contention is resolved round-robin
//          (pointer starts at fetch, moves to the other client after each
//          grant); otherwise data always beats fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // fetch client
  input  logic                    i_f_req_valid,
  output logic                    o_f_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_f_addr,
  output logic                    o_f_resp_valid,
  input  logic                    i_f_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_f_rdata,
  // data client
  input  logic                    i_d_req_valid,
  output logic                    o_d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_d_addr,
  input  logic                    i_d_we,
  input  logic [DATA_WIDTH-1:0]   i_d_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_d_be,
  output logic                    o_d_resp_valid,
  input  logic                    i_d_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_d_rdata,
  // bram_rv side
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  output logic                    o_mem_wr_valid,
  output logic                    o_mem_rd_ready,
  output logic [DATA_WIDTH/8-1:0] o_mem_byte_write_enable,
  input  logic                    i_mem_wr_ready,
  input  logic                    i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_data
);

  localparam int BE_BITS = DATA_WIDTH / 8;

  state_t                state;
  state_t                state_nxt;
  owner_t                owner;
  owner_t                rr_ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_BITS-1:0]    be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  grant_f;
  logic                  grant_d;
  logic                  accept;

  bram_arb_picker u_picker (
    .f_valid (i_f_req_valid),
    .d_valid (i_d_req_valid),
    .rr_ptr  (rr_ptr),
    .grant_f (grant_f),
    .grant_d (grant_d)
  );

  // Request readies are combinational from the valids, so while reset is
  // held they are forced low explicitly; every other output follows from
  // the reset state alone.
  assign accept = (state == IDLE) && i_rst_n && (grant_f || grant_d);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Transaction capture and response register. The read/write kind is not
  // stored separately: it is implied by entering RD or WR.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner   <= OWN_F;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner   <= grant_d ? OWN_D : OWN_F;
        addr_q  <= grant_d ? i_d_addr : i_f_addr;
        wdata_q <= (grant_d && i_d_we) ? i_d_wdata : '0;
        be_q    <= (grant_d && i_d_we) ? i_d_be : '0;
      end
      if ((state == RD) && i_mem_rd_valid) rdata_q <= i_mem_data;
      // Write completion reports zero data to the owner.
      if ((state == WR) && i_mem_wr_ready) rdata_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer: names the client preferred at the next contention.
  // --------------------------------------------------------------------------
`ifdef BRAM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rr_ptr <= OWN_F;
    else if (accept) rr_ptr <= other_port(grant_d ? OWN_D : OWN_F);
  end
`else
  assign rr_ptr = OWN_F;
`endif

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt               = state;
    o_f_req_ready           = 1'b0;
    o_d_req_ready           = 1'b0;
    o_f_resp_valid          = 1'b0;
    o_d_resp_valid          = 1'b0;
    o_f_rdata               = '0;
    o_d_rdata               = '0;
    o_mem_addr              = '0;
    o_mem_data              = '0;
    o_mem_wr_valid          = 1'b0;
    o_mem_rd_ready          = 1'b0;
    o_mem_byte_write_enable = '0;

    case (state)
      IDLE: begin
        if (i_rst_n) begin
          o_f_req_ready = grant_f;
          o_d_req_ready = grant_d;
        end
        if (accept) state_nxt = (grant_d && i_d_we) ? WR : RD;
      end

      RD: begin
        o_mem_rd_ready = 1'b1;
        o_mem_addr     = addr_q;
        if (i_mem_rd_valid) state_nxt = RESP;
      end

      WR: begin
        o_mem_wr_valid          = 1'b1;
        o_mem_addr              = addr_q;
        o_mem_data              = wdata_q;
        o_mem_byte_write_enable = be_q;
        if (i_mem_wr_ready) state_nxt = RESP;
      end

      RESP: begin
        // No grant is offered here, so a completed response always costs
        // one idle cycle before the next acceptance.
        if (owner == OWN_D) begin
          o_d_resp_valid = 1'b1;
          o_d_rdata      = rdata_q;
          if (i_d_resp_ready) state_nxt = IDLE;
        end else begin
          o_f_resp_valid = 1'b1;
          o_f_rdata      = rdata_q;
          if (i_f_resp_ready) state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
// Module : tb_bram_arbiter
// Purpose: Self-checking bench for bram_arbiter with a behavioural bram_rv
//          model (one-cycle read latency, same-cycle write acceptance, with
//          optional random stalls) and a transaction-level reference model.
// Config : honours BRAM_ARB_RR_EN to pick the expected arbitration policy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          f_req_valid = 0, f_resp_ready = 1;
  logic [AW-1:0] f_addr = '0;
  logic          d_req_valid = 0, d_we = 0, d_resp_ready = 1;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          mem_wr_ready = 1, mem_rd_valid = 0;
  logic [DW-1:0] mem_rdata = '0;

  logic          f_req_ready, f_resp_valid, d_req_ready, d_resp_valid;
  logic [DW-1:0] f_rdata, d_rdata, mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_valid, mem_rd_ready;
  logic [BW-1:0] mem_be;

  wire [115:0] all_out = {f_req_ready, d_req_ready, f_resp_valid, d_resp_valid,
                          mem_wr_valid, mem_rd_ready, mem_addr, mem_data, mem_be,
                          f_rdata, d_rdata};

  int checks = 0;
  int errors = 0;
  bit stall_en = 0;
  bit pref_d = 0;   // reference: client preferred on contention (round-robin)

  logic [DW-1:0] bram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_f_req_valid(f_req_valid), .o_f_req_ready(f_req_ready), .i_f_addr(f_addr),
    .o_f_resp_valid(f_resp_valid), .i_f_resp_ready(f_resp_ready), .o_f_rdata(f_rdata),
    .i_d_req_valid(d_req_valid), .o_d_req_ready(d_req_ready), .i_d_addr(d_addr),
    .i_d_we(d_we), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_resp_valid(d_resp_valid), .i_d_resp_ready(d_resp_ready), .o_d_rdata(d_rdata),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_wr_valid(mem_wr_valid),
    .o_mem_rd_ready(mem_rd_ready), .o_mem_byte_write_enable(mem_be),
    .i_mem_wr_ready(mem_wr_ready), .i_mem_rd_valid(mem_rd_valid), .i_mem_data(mem_rdata)
  );

  // bram_rv model
  always @(posedge clk) begin
    if (mem_wr_valid && mem_wr_ready)
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) bram[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
    if (mem_rd_ready && (!stall_en || ($urandom_range(0, 1) == 1))) begin
      mem_rd_valid <= 1'b1;
      mem_rdata    <= bram[mem_addr];
    end else begin
      mem_rd_valid <= 1'b0;
      mem_rdata    <= $urandom;
    end
    mem_wr_ready <= !stall_en || ($urandom_range(0, 1) == 1);
  end

  task automatic init_mem();
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      bram[i] = v;
      ref_mem[i] = v;
    end
    bram[0] = 32'h01000093; ref_mem[0] = 32'h01000093;
    bram[4] = 32'h0100900B; ref_mem[4] = 32'h0100900B;
    bram[8] = 32'h11110000; ref_mem[8] = 32'h11110000;
  endtask

  task automatic reset_dut();
    f_req_valid = 0; d_req_valid = 0; f_resp_ready = 1; d_resp_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    pref_d = 0;
  endtask

  // One transaction on one client; starts and ends 1 time unit after posedge.
  task automatic xact(input bit is_d, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                      output int acc_wait, output int lat, output logic [DW-1:0] rdata);
    acc_wait = -1; lat = -1; rdata = 'x;
    if (is_d) begin
      d_req_valid = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      f_req_valid = 1; f_addr = addr;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (is_d ? d_req_ready : f_req_ready) begin acc_wait = c; break; end
    end
    @(posedge clk); #1;
    f_req_valid = 0; d_req_valid = 0;
    if (acc_wait >= 0) begin
      pref_d = !is_d;
      for (int c = 1; c < 20; c++) begin
        @(negedge clk);
        if (is_d ? d_resp_valid : f_resp_valid) begin
          lat = c; rdata = is_d ? d_rdata : f_rdata; break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    f_req_valid = 1; d_req_valid = 1; rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_hold got %h want 0", all_out); end
    f_req_valid = 0; d_req_valid = 0; rst_n = 1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle got %h want 0", all_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_read();
    int aw, lat; logic [DW-1:0] rd;
    xact(0, 0, 10'h004, '0, '0, aw, lat, rd);
    checks++;
    if (aw !== 0) begin errors++; $display("FAIL f_accept got %0d want 0", aw); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL f_latency got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h0100900B) begin errors++; $display("FAIL f_rdata got %h want 0100900b", rd); end
  endtask

  task automatic test_write_read();
    int aw, lat; logic [DW-1:0] rd;
    xact(1, 1, 10'h008, 32'hA5A5A5A5, 4'b0011, aw, lat, rd);
    checks++;
    if (aw !== 0 || lat !== 2) begin errors++; $display("FAIL d_wr_timing got acc %0d lat %0d want 0 2", aw, lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL d_wr_rdata got %h want 0", rd); end
    xact(1, 0, 10'h008, '0, 4'hF, aw, lat, rd);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL d_rd_latency got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h1111A5A5) begin errors++; $display("FAIL d_rd_merge got %h want 1111a5a5", rd); end
    ref_mem[8] = 32'h1111A5A5;
  endtask

  task automatic test_resp_hold();
    bit ok;
    d_resp_ready = 0; d_req_valid = 1; d_we = 0; d_addr = 10'h008;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_req_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_accept got 0 want 1"); end
    @(posedge clk); #1;
    d_req_valid = 0; pref_d = 0; f_req_valid = 1; f_addr = 10'h000;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_resp_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok || d_rdata !== 32'h1111A5A5) begin
      errors++; $display("FAIL hold_first got v%0d %h want v1 1111a5a5", ok, d_rdata);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({d_resp_valid, d_rdata, f_req_ready} !== {1'b1, 32'h1111A5A5, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable got v%0d %h fr%0d want v1 1111a5a5 fr0", d_resp_valid, d_rdata, f_req_ready);
      end
    end
    @(posedge clk); #1 d_resp_ready = 1;
    @(negedge clk);
    checks++;
    if (d_resp_valid !== 1 || f_req_ready !== 0) begin
      errors++; $display("FAIL hold_bubble got v%0d fr%0d want v1 fr0", d_resp_valid, f_req_ready);
    end
    @(negedge clk);
    checks++;
    if (f_req_ready !== 1 || d_resp_valid !== 0) begin
      errors++; $display("FAIL hold_f_grant got fr%0d v%0d want fr1 v0", f_req_ready, d_resp_valid);
    end
    @(posedge clk); #1;
    f_req_valid = 0; pref_d = 1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (f_resp_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok || f_rdata !== 32'h01000093) begin
      errors++; $display("FAIL hold_f_data got v%0d %h want v1 01000093", ok, f_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    int got; bit ord[2]; bit win_d, fa, da;
    for (int r = 0; r < 4; r++) begin
      win_d = RR ? pref_d : 1'b1;
      f_req_valid = 1; f_addr = AW'(r); d_req_valid = 1; d_we = 0; d_addr = AW'(4 + r);
      got = 0;
      for (int c = 0; c < 40 && got < 2; c++) begin
        @(negedge clk);
        fa = f_req_valid && f_req_ready;
        da = d_req_valid && d_req_ready;
        if (da && got < 2) begin ord[got] = 1'b1; got++; pref_d = 0; end
        if (fa && got < 2) begin ord[got] = 1'b0; got++; pref_d = 1; end
        @(posedge clk); #1;
        if (fa) f_req_valid = 0;
        if (da) d_req_valid = 0;
      end
      checks++;
      if (got !== 2) begin errors++; $display("FAIL prio_grants round %0d got %0d want 2", r, got); end
      checks++;
      if (ord[0] !== win_d || ord[1] !== !win_d) begin
        errors++; $display("FAIL prio_order round %0d got d%0d,d%0d want d%0d,d%0d", r, ord[0], ord[1], win_d, !win_d);
      end
      f_req_valid = 0; d_req_valid = 0;
      repeat (5) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_rd();
    int aw, lat; logic [DW-1:0] rd;
    f_req_valid = 1; f_addr = 10'h004;
    @(negedge clk);
    @(posedge clk); #1 f_req_valid = 0;
    checks++;
    if (mem_rd_ready !== 1 || mem_addr !== 10'h004) begin
      errors++; $display("FAIL rd_active got rr%0d a%h want rr1 a004", mem_rd_ready, mem_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL async_reset got %h want 0", all_out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1; pref_d = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle got %h want 0", all_out); end
    @(posedge clk); #1;
    xact(0, 0, 10'h000, '0, '0, aw, lat, rd);
    checks++;
    if (lat !== 3 || rd !== 32'h01000093) begin
      errors++; $display("FAIL post_reset_read got lat %0d %h want 3 01000093", lat, rd);
    end
  endtask

  task automatic test_random(input int ncyc);
    bit busy, own_d, exp_we, mem_done, fa, da, hs, win_d, draining;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, exp_wdata;
    logic [BW-1:0] exp_be;
    int busy_cnt;
    busy = 0; own_d = 0; exp_we = 0; mem_done = 0; busy_cnt = 0;
    exp_addr = '0; exp_data = '0; exp_wdata = '0; exp_be = '0;
    stall_en = 1;
    init_mem();
    reset_dut();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      fa = f_req_valid && f_req_ready;
      da = d_req_valid && d_req_ready;
      checks++;
      if ((f_req_ready && d_req_ready) || (f_req_ready && !f_req_valid) || (d_req_ready && !d_req_valid)) begin
        errors++; $display("FAIL rnd_ready_rule got fv%0d fr%0d dv%0d dr%0d", f_req_valid, f_req_ready, d_req_valid, d_req_ready);
      end
      if (busy) begin
        checks++;
        if (f_req_ready || d_req_ready) begin
          errors++; $display("FAIL rnd_ready_busy got fr%0d dr%0d want 0 0", f_req_ready, d_req_ready);
        end
      end else if (f_req_valid || d_req_valid) begin
        checks++;
        if (!fa && !da) begin errors++; $display("FAIL rnd_no_grant got 0 want 1"); end
        if (f_req_valid && d_req_valid) begin
          win_d = RR ? pref_d : 1'b1;
          checks++;
          if (da !== win_d || fa !== !win_d) begin
            errors++; $display("FAIL rnd_winner got d%0d f%0d want d%0d", da, fa, win_d);
          end
        end
      end
      checks++;
      if (mem_rd_ready && mem_wr_valid) begin
        errors++; $display("FAIL rnd_mem_both got rr1 wv1 want exclusive");
      end else if (mem_rd_ready) begin
        if (!busy || exp_we || mem_done || mem_addr !== exp_addr || mem_be !== '0) begin
          errors++; $display("FAIL rnd_mem_rd got a%h be%h want a%h be0 busy%0d", mem_addr, mem_be, exp_addr, busy);
        end
      end else if (mem_wr_valid) begin
        if (!busy || !exp_we || mem_done || mem_addr !== exp_addr || mem_data !== exp_wdata || mem_be !== exp_be) begin
          errors++; $display("FAIL rnd_mem_wr got a%h d%h be%h want a%h d%h be%h", mem_addr, mem_data, mem_be, exp_addr, exp_wdata, exp_be);
        end
      end else if (mem_addr !== '0 || mem_data !== '0 || mem_be !== '0) begin
        errors++; $display("FAIL rnd_mem_idle got a%h d%h be%h want 0", mem_addr, mem_data, mem_be);
      end
      checks++;
      if (f_resp_valid || d_resp_valid) begin
        if (!busy || !mem_done || (f_resp_valid && d_resp_valid) || d_resp_valid !== own_d ||
            (own_d ? d_rdata : f_rdata) !== exp_data) begin
          errors++; $display("FAIL rnd_resp got fv%0d dv%0d f%h d%h want owner_d%0d %h", f_resp_valid, d_resp_valid, f_rdata, d_rdata, own_d, exp_data);
        end
      end else if (f_rdata !== '0 || d_rdata !== '0) begin
        errors++; $display("FAIL rnd_rdata_idle got %h %h want 0", f_rdata, d_rdata);
      end
      if (busy && ((mem_rd_ready && mem_rd_valid) || (mem_wr_valid && mem_wr_ready))) mem_done = 1;
      hs = own_d ? (d_resp_valid && d_resp_ready) : (f_resp_valid && f_resp_ready);
      if (busy) begin
        if (hs) busy = 0;
        else begin
          busy_cnt++;
          if (busy_cnt > 64) begin
            checks++; errors++; $display("FAIL rnd_timeout got busy %0d cycles want <=64", busy_cnt);
            break;
          end
        end
      end else if (fa || da) begin
        busy = 1; busy_cnt = 0; mem_done = 0; own_d = da;
        exp_we = da && d_we;
        exp_addr = da ? d_addr : f_addr;
        exp_wdata = exp_we ? d_wdata : '0;
        exp_be = exp_we ? d_be : '0;
        if (exp_we) begin
          for (int b = 0; b < BW; b++)
            if (d_be[b]) ref_mem[exp_addr][8*b +: 8] = d_wdata[8*b +: 8];
          exp_data = '0;
        end else begin
          exp_data = ref_mem[exp_addr];
        end
        pref_d = !da;
      end
      @(posedge clk); #1;
      draining = (cyc >= ncyc - 100);
      if (!f_req_valid || fa || ($urandom_range(0, 9) == 0)) begin
        f_req_valid = !draining && ($urandom_range(0, 2) != 0);
        f_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req_valid || da || ($urandom_range(0, 9) == 0)) begin
        d_req_valid = !draining && ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
        d_be = BW'($urandom_range(0, 15));
      end
      f_resp_ready = $urandom_range(0, 3) != 0;
      d_resp_ready = $urandom_range(0, 3) != 0;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL rnd_drain got busy want idle"); end
    f_req_valid = 0; d_req_valid = 0; f_resp_ready = 1; d_resp_ready = 1;
    stall_en = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    init_mem();
    test_reset();
    test_fetch_read();
    test_write_read();
    test_resp_hold();
    reset_dut();
    test_priority();
    test_reset_mid_rd();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
